fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating stall counter.
REQ-002 Port: clk_i  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_i  in  1  reset, asynchronous and active-low.
REQ-004 Port: id_valid_i  in  1  ID stage holds a real instruction.
REQ-005 Port: id_rs_i  in  5  ID instruction source register A.
REQ-006 Port: id_rt_i  in  5  ID instruction source register B.
REQ-007 Port: id_rd_i  in  5  ID instruction destination, post RegDst selection.
REQ-008 Port: id_regwrite_i  in  1  ID instruction writes the register file.
REQ-009 Port: id_memread_i  in  1  ID instruction is a load.
REQ-010 Port: flush_i  in  1  squash the ID instruction (taken branch/jump).
REQ-011 Port: fwdA_o  out  2  select for EX operand-A 3-to-1 mux.
REQ-012 Port: fwdB_o  out  2  select for EX operand-B 3-to-1 mux.
REQ-013 Port: stall_o  out  1  load-use stall; PC and IF/ID hold.
REQ-014 Port: stall_cnt_o  out  CNT_W  count of stall cycles since reset.

Function
REQ-015 The block SHALL keep three shadow slots, EX, MEM and WB, that mirror the CPU pipeline. Each slot holds rs, rt, rd, regwrite and memread.
REQ-016 Every rising edge SHALL advance the slots: WB<=MEM and MEM<=EX.
REQ-017 On the same edge, EX SHALL load the ID fields, or a bubble (all fields 0) when stall_o=1, flush_i=1 or id_valid_i=0.
REQ-018 A slot "writes r" only when its regwrite=1 and rd=r and r!=0. Register 0 SHALL never cause forwarding or stall.
REQ-019 Select encoding SHALL be as follows: 0 = register-file operand; 1 = MEM/WB write-back data; 2 = EX/MEM ALU result. Value 3 SHALL never be driven.
REQ-020 fwdA_o SHALL be 2 if the MEM slot writes EX.rs. Otherwise it SHALL be 1 if the WB slot writes EX.rs. Otherwise it SHALL be 0.
REQ-021 fwdB_o SHALL follow the same rule using EX.rt.
REQ-022 When both MEM and WB slots match, MEM (2) SHALL win.
REQ-023 fwdA_o and fwdB_o SHALL be decoded only from slot registers, with no combinational path from any input. They apply to the instruction currently in EX.
REQ-024 stall_o SHALL be 1 when all of the following hold: id_valid_i=1, flush_i=0, EX.memread=1, and the EX slot writes id_rs_i or id_rt_i. It is combinational.
REQ-025 A stall SHALL last exactly one cycle per load-use pair. The bubble it inserts clears EX.memread, so stall_o deasserts the next cycle and the dependent then receives select 1 from WB.
REQ-026 When stall_o=1 and flush_i=1 coincide, flush SHALL win: stall_o=0 and EX receives a bubble.
REQ-027 A MEM slot with memread=1 matching EX.rs or EX.rt is unreachable. The select SHALL still be 2, and verification SHALL flag it.
REQ-028 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-029 The block SHALL NOT forward from WB into ID; the register file is write-through.

Reset
REQ-030 While rst_i=0, all slots SHALL clear asynchronously to bubbles and stall_cnt_o SHALL be 0. Consequently fwdA_o=0, fwdB_o=0 and stall_o=0, since EX.memread=0.
REQ-031 Reset asserted mid-pipeline SHALL discard all slot contents immediately.
REQ-032 After reset deasserts, the first edge SHALL load EX normally, with no extra bubble.
REQ-033 No output SHALL be X after reset.

Verification
REQ-034 Back-to-back ALU dependency: add r3,r1,r2 then sub r4,r3,r5 -> in sub's EX cycle, fwdA_o=2 and fwdB_o=0; stall_o stays 0.
REQ-035 Distance-2 dependency with a double hit: add r3; add r3; or r6,r3,r3 -> fwdA_o=fwdB_o=2 (MEM wins). Repeat with one unrelated instruction between the writer and the reader -> fwdA_o=fwdB_o=1.
REQ-036 Load-use: lw r8 then add r9,r8,r8 -> stall_o=1 for exactly one cycle and stall_cnt_o goes 0->1. In add's EX cycle, fwdA_o=fwdB_o=1.
REQ-037 r0 and flush: writer to r0 followed by a reader of r0 -> selects 0. Load-use with flush_i=1 in the same cycle -> stall_o=0, stall_cnt_o unchanged, EX bubble.
REQ-038 Saturation and reset: with CNT_W=2, force 5 stalls -> stall_cnt_o=3. Then pulse rst_i low between edges -> outputs 0 immediately, and the next instruction stream forwards correctly.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit for a 5-stage pipeline.
// Keeps EX/MEM/WB shadow slots of register ids and decodes operand selects from them.
module fwd_hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } slot_t;

    localparam slot_t Bubble = '0;

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic slot_writes(slot_t s, logic [4:0] r);
        return s.regwrite && (s.rd == r) && (r != 5'd0);
    endfunction

    // MEM wins over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(logic [4:0] r);
        if (slot_writes(mem_q, r)) begin
            return 2'd2;
        end else if (slot_writes(wb_q, r)) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

    always_comb begin
        fwdA_o = fwd_sel(ex_q.rs);
        fwdB_o = fwd_sel(ex_q.rt);
    end

    always_comb begin
        stall_o = id_valid_i && !flush_i && ex_q.memread &&
                  (slot_writes(ex_q, id_rs_i) || slot_writes(ex_q, id_rt_i));
    end

    always_comb begin
        ex_d = Bubble;
        if (id_valid_i && !flush_i && !stall_o) begin
            ex_d.rs       = id_rs_i;
            ex_d.rt       = id_rt_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= Bubble;
            mem_q <= Bubble;
            wb_q  <= Bubble;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed hazard sequences with literal expectations,
// then random instruction streams checked every cycle against an in-order pipeline model.
module tb_fwd_hazard_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs_i = '0;
    logic [4:0] id_rt_i = '0;
    logic [4:0] id_rd_i = '0;
    logic       id_regwrite_i = 1'b0;
    logic       id_memread_i = 1'b0;
    logic       flush_i = 1'b0;

    logic [1:0]  fwda, fwdb, fwda2, fwdb2;
    logic        stall, stall2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    fwd_hazard_unit #(.CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .fwdA_o(fwda), .fwdB_o(fwdb),
        .stall_o(stall), .stall_cnt_o(cnt)
    );

    fwd_hazard_unit #(.CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .fwdA_o(fwda2), .fwdB_o(fwdb2),
        .stall_o(stall2), .stall_cnt_o(cnt2)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model: list of in-flight instructions ----------------
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    ins_t pipe [3];  // [0]=EX, [1]=MEM, [2]=WB
    int   m_cnt16 = 0;
    int   m_cnt2 = 0;

    function automatic bit writes(ins_t s, logic [4:0] r);
        return s.rw && s.rd == r && r != 0;
    endfunction

    function automatic int exp_sel(logic [4:0] r);
        if (writes(pipe[1], r)) return 2;
        if (writes(pipe[2], r)) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        return id_valid_i && !flush_i && pipe[0].mr &&
               (writes(pipe[0], id_rs_i) || writes(pipe[0], id_rt_i));
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 3; i++) pipe[i] <= '0;
            m_cnt16 <= 0;
            m_cnt2  <= 0;
        end else begin
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            if (exp_stall() || flush_i || !id_valid_i) pipe[0] <= '0;
            else pipe[0] <= '{id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i};
            if (exp_stall()) begin
                m_cnt16 <= (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
                m_cnt2  <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
    end

    // ---------------- compare process ----------------
    int vectors = 0;
    int miscompares = 0;
    int unreach_hits = 0;
    bit started = 0;
    bit lit_en = 0;
    int lit_a, lit_b, lit_s, lit_cnt, lit_cnt2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (started) begin
            chk("fwdA", 32'(fwda), 32'(exp_sel(pipe[0].rs)));
            chk("fwdB", 32'(fwdb), 32'(exp_sel(pipe[0].rt)));
            chk("stall", 32'(stall), 32'(exp_stall()));
            chk("stall_cnt", 32'(cnt), 32'(m_cnt16));
            chk("fwdA_w2", 32'(fwda2), 32'(exp_sel(pipe[0].rs)));
            chk("fwdB_w2", 32'(fwdb2), 32'(exp_sel(pipe[0].rt)));
            chk("stall_w2", 32'(stall2), 32'(exp_stall()));
            chk("stall_cnt_w2", 32'(cnt2), 32'(m_cnt2));
            if (pipe[1].mr && (writes(pipe[1], pipe[0].rs) || writes(pipe[1], pipe[0].rt)))
                unreach_hits++;
            if (lit_en) begin
                chk("lit_fwdA", 32'(fwda), 32'(lit_a));
                chk("lit_fwdB", 32'(fwdb), 32'(lit_b));
                chk("lit_stall", 32'(stall), 32'(lit_s));
                if (lit_cnt >= 0) chk("lit_cnt", 32'(cnt), 32'(lit_cnt));
                if (lit_cnt2 >= 0) chk("lit_cnt_w2", 32'(cnt2), 32'(lit_cnt2));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit v, input int rs, input int rt, input int rd,
                         input bit rw, input bit mr, input bit fl,
                         input bit lit = 0, input int ea = 0, input int eb = 0,
                         input int es = 0, input int ec = -1, input int ec2 = -1);
        @(posedge clk_i);
        #1;
        id_valid_i    = v;
        id_rs_i       = 5'(rs);
        id_rt_i       = 5'(rt);
        id_rd_i       = 5'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        lit_en   = lit;
        lit_a    = ea;
        lit_b    = eb;
        lit_s    = es;
        lit_cnt  = ec;
        lit_cnt2 = ec2;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset pulse between two edges; outputs must clear before the next edge.
    task automatic rst_pulse(input bit lit);
        issue(0, 0, 0, 0, 0, 0, 0, lit, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
    endtask

    initial begin
        #1 rst_i = 1'b0;
        started = 1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // load-use: lw r8 ; add r9,r8,r8
        issue(1, 1, 0, 8, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        issue(1, 8, 8, 9, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        issue(1, 8, 8, 9, 1, 0, 0, 1, 0, 0, 0, 1, 1);
        issue(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        nops(3);

        // add r3,r1,r2 ; sub r4,r3,r5
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 3, 5, 4, 1, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        nops(3);

        // add r3 ; add r3 ; or r6,r3,r3 -> MEM wins
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 3, 3, 6, 1, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
        nops(3);
        // add r3 ; and r7 ; or r6,r3,r3 -> WB
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 1, 2, 7, 1, 0, 0);
        issue(1, 3, 3, 6, 1, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        nops(3);

        // r0 never forwards
        issue(1, 1, 2, 0, 1, 0, 0);
        issue(1, 0, 0, 4, 1, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        nops(3);
        // load-use with coincident flush
        issue(1, 1, 0, 8, 1, 1, 0);
        issue(1, 8, 8, 9, 1, 0, 1, 1, 0, 0, 0, 1, 1);
        issue(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        nops(3);

        // five more stalls: 16-bit counter reaches 6, 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            issue(1, 1, 0, 8, 1, 1, 0);
            issue(1, 8, 8, 9, 1, 0, 0);
            issue(1, 8, 8, 9, 1, 0, 0);
            nops(2);
        end
        issue(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6, 3);

        // reset mid-pipeline, then a fresh stream forwards immediately
        issue(1, 1, 2, 3, 1, 0, 0);
        issue(1, 3, 5, 4, 1, 0, 0);
        rst_pulse(1);
        issue(1, 1, 2, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        issue(1, 3, 5, 4, 1, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        nops(3);

        // random streams over a small register set to get frequent hits
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_pulse(0);
            end else begin
                issue($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 99) < 75,
                      $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10);
            end
        end
        nops(2);
        @(posedge clk_i);
        if (unreach_hits != 0)
            $display("note: %0d cycles with a load in MEM matching an EX source", unreach_hits);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
